pu_or1k_wb_mux_pipelined: RTL and testbench
===========================================

Name: pu_or1k_wb_mux_pipelined

Overview:
Parametrised writeback stage for the OR1K pipeline. It selects one of NUM_SRC single-cycle result sources by one-hot select and registers the result toward the register file. It also tracks up to LATE_DEPTH outstanding multicycle results (mul/div) in an in-order tag FIFO and writes them back when they complete. It sits between execute and the register file and produces the RF write strobe, write address and issue backpressure.

Parameters:
OPTION_OPERAND_WIDTH, 32, result data width
OPTION_RF_ADDR_WIDTH, 5, register-file address width
NUM_SRC, 4, number of single-cycle result sources (≥2)
LATE_DEPTH, 4, maximum outstanding late results (power of two, ≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
issue_valid_i  in  1  op presented to writeback this cycle
issue_ready_o  out  1  op accepted this cycle (combinational)
issue_sel_i  in  NUM_SRC  one-hot source select for early ops
issue_late_i  in  1  result will arrive later on the late channel
issue_rf_wb_i  in  1  op writes the register file
issue_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  destination register
src_data_i  in  NUM_SRC*OPTION_OPERAND_WIDTH  packed early sources; source k occupies bits [k*W +: W]
late_valid_i  in  1  late result valid, in issue order
late_data_i  in  OPTION_OPERAND_WIDTH  late result data
flush_i  in  1  pipeline flush
rf_wb_o  out  1  RF write strobe, one-cycle pulse
rf_wb_adr_o  out  OPTION_RF_ADDR_WIDTH  RF write address
rf_result_o  out  OPTION_OPERAND_WIDTH  RF write data
late_pending_o  out  clog2(LATE_DEPTH)+1  outstanding late ops
late_orphan_o  out  1  one-cycle pulse: late_valid_i seen with FIFO empty

Behaviour:
- Reset (rst=0, async): rf_wb_o=0, rf_wb_adr_o=0, rf_result_o=0, late_orphan_o=0, FIFO empty, late_pending_o=0.
- Early op (issue_late_i=0) accepted: next cycle rf_wb_o=issue_rf_wb_i, rf_wb_adr_o=issue_rfd_adr_i, rf_result_o=selected source. Latency is 1 cycle.
- Select with zero or multiple bits set is illegal. The RTL ORs the gated sources together; the bench asserts one-hot.
- Late op accepted: push {rf_wb, rfd_adr} into the tag FIFO. Produces no write that cycle (rf_wb_o=0 next cycle).
- late_valid_i with FIFO non-empty: pop the head tag. Next cycle rf_wb_o=head.rf_wb, rf_wb_adr_o=head.adr, rf_result_o=late_data_i.
- Only one RF write per cycle. The late result has priority over an early issue.
- issue_ready_o = !(late_valid_i && fifo_nonempty && issue_valid_i && !issue_late_i) && !(issue_late_i && fifo_full_after_pop).
- A late push is allowed on the same cycle as a late pop even when the FIFO is full. The count is unchanged.
- A late issue on the same cycle as a late result is accepted (push and pop together).
- An issue that is not accepted does not change state. The issuer holds its inputs.
- late_valid_i with FIFO empty (and no same-cycle push): data dropped, no write, late_orphan_o pulses next cycle.
- flush_i: FIFO cleared and pending count reset to 0 next cycle. A same-cycle issue is not accepted (issue_ready_o=0). A same-cycle late_valid_i is discarded without an orphan pulse.
- When rf_wb_o=0, rf_wb_adr_o and rf_result_o hold their previous values.
- FIFO pointers are log2(LATE_DEPTH) bits and wrap modulo depth. Full/empty are derived from the separate count register.

Decomposition:
- Package pu_or1k_wb_pkg: wb_tag_t struct {rf_wb, rfd_adr}, function for the pending-count width.
- One sub-module, pu_or1k_wb_tag_fifo: synchronous FIFO with push, pop, flush, count, full and empty, and async active-low reset.
- Source mux, arbitration and output registers live in the top module.

Test Plan:
- Reset mid-stream: hold rst=0 with a pending late op → all outputs 0, late_pending_o=0; the subsequent late_valid_i produces late_orphan_o=1.
- Early op, sel=4'b0100, src2=0xDEADBEEF, adr=7, rf_wb=1 → next cycle rf_wb_o=1, adr=7, result=0xDEADBEEF.
- Two late ops (adr 3 then 9), then late_valid_i with 0x11 and later 0x22 → writes (3,0x11) then (9,0x22) in order; late_pending_o goes 2→1→0.
- Collision: late_valid_i and an early issue in the same cycle → issue_ready_o=0, late result written; the early op is accepted the following cycle and written one cycle after that.
- Full: LATE_DEPTH=4 with 4 outstanding plus a 5th late issue → issue_ready_o=0; with late_valid_i in the same cycle → accepted, count stays 4.
- Flush with 3 pending → count 0; the next late_valid_i gives no write and late_orphan_o=1.

Source files
------------

// File: rtl/pu_or1k_wb_mux_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pu_or1k_wb_pkg
// Purpose  : Shared types and helpers for the OR1K writeback stage.
//            wb_tag_t is the tag stored per outstanding late (mul/div) op.
// Revision : 1.0 - initial release
// ============================================================================
package pu_or1k_wb_pkg;

  // Architectural OR1K GPR address width; tags are stored at this width.
  localparam int WB_RF_ADDR_WIDTH = 5;

  typedef struct packed {
    logic                        rf_wb;
    logic [WB_RF_ADDR_WIDTH-1:0] rfd_adr;
  } wb_tag_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int pend_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pu_or1k_wb_mux_pipelined_if.sv
`default_nettype none
// ============================================================================
// Interface : pu_or1k_wb_mux_pipelined_if
// Purpose   : Execute-to-writeback bus: issue handshake, early result
//             sources, late result channel and flush.
// Modports  : master - execute side (drives issue/late/flush, sees ready)
//             slave  - writeback stage
// Revision  : 1.0 - initial release
// ============================================================================
interface pu_or1k_wb_mux_pipelined_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_SRC              = 4
);
  logic                                issue_valid_i;
  logic                                issue_ready_o;
  logic [NUM_SRC-1:0]                  issue_sel_i;
  logic                                issue_late_i;
  logic                                issue_rf_wb_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0]     issue_rfd_adr_i;
  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_data_i;
  logic                                late_valid_i;
  logic [OPTION_OPERAND_WIDTH-1:0]     late_data_i;
  logic                                flush_i;

  modport master (
    output issue_valid_i, issue_sel_i, issue_late_i, issue_rf_wb_i,
           issue_rfd_adr_i, src_data_i, late_valid_i, late_data_i, flush_i,
    input  issue_ready_o
  );

  modport slave (
    input  issue_valid_i, issue_sel_i, issue_late_i, issue_rf_wb_i,
           issue_rfd_adr_i, src_data_i, late_valid_i, late_data_i, flush_i,
    output issue_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/pu_or1k_wb_mux_pipelined_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pu_or1k_wb_tag_fifo
// Purpose  : In-order tag FIFO for outstanding late results.
// Ports    : clk, rst_n (async active-low), push_i/data_i, pop_i/data_o
//            (head, valid when !empty_o), flush_i, count_o, full_o, empty_o
// Revision : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_tag_fifo
  import pu_or1k_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  wb_tag_t                   data_i,
  output wb_tag_t                   data_o,
  output logic [pend_w(DEPTH)-1:0]  count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = pend_w(DEPTH);

  wb_tag_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  // The caller only pushes when not full or when popping in the same cycle,
  // so a simultaneous push/pop at full leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        // Power-of-two depth: pointers wrap naturally.
        if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pu_or1k_wb_mux_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : pu_or1k_wb_mux_pipelined
// Purpose  : OR1K writeback stage. Selects one of NUM_SRC single-cycle
//            results and registers it toward the RF; tracks up to LATE_DEPTH
//            outstanding multicycle results in issue order.
// Ports    : clk, rst (async active-low), bus (slave modport: issue
//            handshake, sources, late channel, flush), rf_wb_o/rf_wb_adr_o/
//            rf_result_o (RF write), late_pending_o, late_orphan_o
// Revision : 1.0 - initial release
// ============================================================================
module pu_or1k_wb_mux_pipelined
  import pu_or1k_wb_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_SRC              = 4,
  parameter int LATE_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  pu_or1k_wb_mux_pipelined_if.slave        bus,
  output logic                             rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]  rf_wb_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  rf_result_o,
  output logic [pend_w(LATE_DEPTH)-1:0]    late_pending_o,
  output logic                             late_orphan_o
);
  localparam int W = OPTION_OPERAND_WIDTH;

  logic    fifo_full, fifo_empty;
  wb_tag_t tag_in, tag_head;
  logic [W-1:0] early_res;
  logic    late_pop, push, early_wr, accept, full_after_pop, orphan;

  logic                            rf_wb_q,    rf_wb_d;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rf_adr_q,   rf_adr_d;
  logic [W-1:0]                    rf_res_q,   rf_res_d;
  logic                            orphan_q;

  // Gated-OR mux; a non-one-hot select is illegal and simply ORs sources.
  always_comb begin
    early_res = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.issue_sel_i[k]) early_res = early_res | bus.src_data_i[k*W +: W];
    end
  end

  assign late_pop       = bus.late_valid_i && !fifo_empty && !bus.flush_i;
  assign full_after_pop = fifo_full && !late_pop;

  // A late result owns the single RF write port, so an early issue stalls
  // against it; a late issue can still push alongside the pop.
  assign bus.issue_ready_o = !bus.flush_i &&
      !(bus.late_valid_i && !fifo_empty && bus.issue_valid_i && !bus.issue_late_i) &&
      !(bus.issue_late_i && full_after_pop);

  assign accept   = bus.issue_valid_i && bus.issue_ready_o;
  assign push     = accept && bus.issue_late_i;
  assign early_wr = accept && !bus.issue_late_i;

  // A late result with nothing outstanding is an orphan, unless a tag is
  // being pushed in that same cycle (the result is still dropped then).
  assign orphan = bus.late_valid_i && fifo_empty && !bus.flush_i && !push;

  assign tag_in.rf_wb   = bus.issue_rf_wb_i;
  assign tag_in.rfd_adr = WB_RF_ADDR_WIDTH'(bus.issue_rfd_adr_i);

  pu_or1k_wb_tag_fifo #(
    .DEPTH (LATE_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (late_pop),
    .flush_i (bus.flush_i),
    .data_i  (tag_in),
    .data_o  (tag_head),
    .count_o (late_pending_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Address/data only move when a real write happens, so they hold while
  // the strobe is low.
  always_comb begin
    rf_wb_d  = 1'b0;
    rf_adr_d = rf_adr_q;
    rf_res_d = rf_res_q;
    if (late_pop) begin
      rf_wb_d = tag_head.rf_wb;
      if (tag_head.rf_wb) begin
        rf_adr_d = OPTION_RF_ADDR_WIDTH'(tag_head.rfd_adr);
        rf_res_d = bus.late_data_i;
      end
    end else if (early_wr) begin
      rf_wb_d = bus.issue_rf_wb_i;
      if (bus.issue_rf_wb_i) begin
        rf_adr_d = bus.issue_rfd_adr_i;
        rf_res_d = early_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wb_q  <= 1'b0;
      rf_adr_q <= '0;
      rf_res_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      rf_wb_q  <= rf_wb_d;
      rf_adr_q <= rf_adr_d;
      rf_res_q <= rf_res_d;
      orphan_q <= orphan;
    end
  end

  assign rf_wb_o       = rf_wb_q;
  assign rf_wb_adr_o   = rf_adr_q;
  assign rf_result_o   = rf_res_q;
  assign late_orphan_o = orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_or1k_wb_mux_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_or1k_wb_mux_pipelined
// Purpose  : Directed self-checking bench for the OR1K writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_or1k_wb_mux_pipelined;
  logic        clk;
  logic        rst;
  logic        rf_wb;
  logic [4:0]  rf_adr;
  logic [31:0] rf_res;
  logic [2:0]  pend;
  logic        orphan;
  int          n_checks = 0;
  int          n_fail   = 0;

  pu_or1k_wb_mux_pipelined_if #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .NUM_SRC              (4)
  ) bus ();

  pu_or1k_wb_mux_pipelined #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .NUM_SRC              (4),
    .LATE_DEPTH           (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .rf_wb_o        (rf_wb),
    .rf_wb_adr_o    (rf_adr),
    .rf_result_o    (rf_res),
    .late_pending_o (pend),
    .late_orphan_o  (orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Early issues must carry a one-hot select.
  always @(negedge clk) begin
    if (rst && bus.issue_valid_i && !bus.issue_late_i)
      assert ($onehot(bus.issue_sel_i));
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_i   = 1'b0;
    bus.issue_sel_i     = '0;
    bus.issue_late_i    = 1'b0;
    bus.issue_rf_wb_i   = 1'b0;
    bus.issue_rfd_adr_i = '0;
    bus.late_valid_i    = 1'b0;
    bus.late_data_i     = '0;
    bus.flush_i         = 1'b0;
  endtask

  task automatic early(input logic [3:0] sel, input logic [4:0] adr);
    bus.issue_valid_i   = 1'b1;
    bus.issue_late_i    = 1'b0;
    bus.issue_rf_wb_i   = 1'b1;
    bus.issue_sel_i     = sel;
    bus.issue_rfd_adr_i = adr;
  endtask

  task automatic late_issue(input logic [4:0] adr);
    bus.issue_valid_i   = 1'b1;
    bus.issue_late_i    = 1'b1;
    bus.issue_rf_wb_i   = 1'b1;
    bus.issue_sel_i     = '0;
    bus.issue_rfd_adr_i = adr;
  endtask

  task automatic late_result(input logic [31:0] d);
    bus.late_valid_i = 1'b1;
    bus.late_data_i  = d;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] adr, input logic [31:0] res);
    check_eq({tag, "_wb"},  64'(rf_wb),  64'd1);
    check_eq({tag, "_adr"}, 64'(rf_adr), 64'(adr));
    check_eq({tag, "_res"}, 64'(rf_res), 64'(res));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.src_data_i = {32'h4444_4444, 32'hDEAD_BEEF, 32'hCAFE_0001, 32'h1111_1111};
    repeat (2) step();
    check_eq("rst_wb",     64'(rf_wb),  64'd0);
    check_eq("rst_adr",    64'(rf_adr), 64'd0);
    check_eq("rst_res",    64'(rf_res), 64'd0);
    check_eq("rst_pend",   64'(pend),   64'd0);
    check_eq("rst_orphan", 64'(orphan), 64'd0);
    rst = 1'b1;
    step();

    // Early ops through different sources
    early(4'b0100, 5'd7);
    #1 check_eq("rdy_early", 64'(bus.issue_ready_o), 64'd1);
    step();
    check_wr("early2", 5'd7, 32'hDEAD_BEEF);
    idle();
    step();
    check_eq("idle_wb", 64'(rf_wb), 64'd0);
    check_eq("hold_adr", 64'(rf_adr), 64'd7);
    check_eq("hold_res", 64'(rf_res), 64'hDEAD_BEEF);
    early(4'b1000, 5'd30);
    step();
    check_wr("early3", 5'd30, 32'h4444_4444);
    early(4'b0001, 5'd1);
    step();
    check_wr("early0", 5'd1, 32'h1111_1111);
    idle();

    // Two late ops, completed in order
    late_issue(5'd3);
    #1 check_eq("rdy_late", 64'(bus.issue_ready_o), 64'd1);
    step();
    check_eq("late1_wb", 64'(rf_wb), 64'd0);
    check_eq("pend_1", 64'(pend), 64'd1);
    late_issue(5'd9);
    step();
    check_eq("pend_2", 64'(pend), 64'd2);
    idle();
    late_result(32'h11);
    step();
    check_wr("late_a", 5'd3, 32'h11);
    check_eq("pend_a", 64'(pend), 64'd1);
    idle();
    step();
    check_eq("gap_wb", 64'(rf_wb), 64'd0);
    late_result(32'h22);
    step();
    check_wr("late_b", 5'd9, 32'h22);
    check_eq("pend_b", 64'(pend), 64'd0);
    idle();

    // Collision: late result beats an early issue
    late_issue(5'd5);
    step();
    early(4'b0010, 5'd12);
    late_result(32'h33);
    #1 check_eq("rdy_coll", 64'(bus.issue_ready_o), 64'd0);
    step();
    check_wr("coll_late", 5'd5, 32'h33);
    check_eq("pend_coll", 64'(pend), 64'd0);
    bus.late_valid_i = 1'b0;
    #1 check_eq("rdy_retry", 64'(bus.issue_ready_o), 64'd1);
    step();
    check_wr("coll_early", 5'd12, 32'hCAFE_0001);
    idle();

    // Fill the FIFO
    for (int i = 0; i < 4; i++) begin
      late_issue(5'(20 + i));
      step();
    end
    check_eq("pend_full", 64'(pend), 64'd4);
    late_issue(5'd24);
    #1 check_eq("rdy_full", 64'(bus.issue_ready_o), 64'd0);
    step();
    check_eq("pend_stall", 64'(pend), 64'd4);
    check_eq("stall_wb", 64'(rf_wb), 64'd0);
    late_result(32'h44);
    #1 check_eq("rdy_full_pop", 64'(bus.issue_ready_o), 64'd1);
    step();
    check_wr("full_pop", 5'd20, 32'h44);
    check_eq("pend_swap", 64'(pend), 64'd4);
    idle();
    late_result(32'h55);
    step();
    check_wr("drain", 5'd21, 32'h55);
    check_eq("pend_3", 64'(pend), 64'd3);

    // Flush with 3 pending, with a same-cycle early issue
    idle();
    bus.flush_i = 1'b1;
    early(4'b0100, 5'd15);
    #1 check_eq("rdy_flush", 64'(bus.issue_ready_o), 64'd0);
    step();
    check_eq("pend_flush", 64'(pend), 64'd0);
    check_eq("flush_wb", 64'(rf_wb), 64'd0);
    idle();
    late_result(32'h66);
    step();
    check_eq("orph_wb", 64'(rf_wb), 64'd0);
    check_eq("orph_pulse", 64'(orphan), 64'd1);
    idle();
    step();
    check_eq("orph_clear", 64'(orphan), 64'd0);

    // Late result during flush is discarded quietly
    bus.flush_i = 1'b1;
    late_result(32'h67);
    step();
    check_eq("flush_noorph", 64'(orphan), 64'd0);
    idle();

    // Asynchronous reset mid-stream with a pending late op
    late_issue(5'd2);
    step();
    check_eq("pend_pre_rst", 64'(pend), 64'd1);
    idle();
    #1 rst = 1'b0;
    #1;
    check_eq("arst_wb",   64'(rf_wb),  64'd0);
    check_eq("arst_adr",  64'(rf_adr), 64'd0);
    check_eq("arst_res",  64'(rf_res), 64'd0);
    check_eq("arst_pend", 64'(pend),   64'd0);
    step();
    rst = 1'b1;
    late_result(32'h77);
    step();
    check_eq("post_rst_wb", 64'(rf_wb), 64'd0);
    check_eq("post_rst_orph", 64'(orphan), 64'd1);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
